// File: rtl/mem_arbiter.sv
// Purpose: shares one synchronous memory port between instruction fetch and load/store.
// Latency: gnt in T (combinational), mem_en in T+1, rvalid in T+1+MEM_LATENCY (ce-enabled cycles).
// Backpressure: requests wait while an access is in flight; ce=0 freezes all state.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking (default: LS over IF).
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ce,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [DATA_W/8-1:0] ls_be,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int       BE_W   = DATA_W / 8;
   localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t              state, state_nxt;
   logic [2:0]          cnt, cnt_nxt;
   logic                owner_ls, owner_nxt;
   logic                mem_we_nxt;
   logic [BE_W-1:0]     mem_be_nxt;
   logic [ADDR_W-1:0]   mem_addr_nxt;
   logic [DATA_W-1:0]   mem_wdata_nxt;
   logic                pick_ls;
   logic                grant_raw;
   logic                active;

   // Outputs are only live when the core is enabled and out of reset.
   assign active = ce & reset;

`ifdef MEM_ARB_RR_EN
   logic rr_last_if;

   // Remember which port won the most recent grant; reset leaves IF as last so LS wins first.
   always_ff @(posedge clk) begin
      if (!reset)
         rr_last_if <= 1'b1;
      else if (ce && grant_raw)
         rr_last_if <= !pick_ls;
   end

   assign pick_ls = ls_req && (!if_req || rr_last_if);
`else
   assign pick_ls = ls_req;
`endif

   // Next-state, grant selection and access-register loading.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      owner_nxt     = owner_ls;
      mem_we_nxt    = mem_we;
      mem_be_nxt    = mem_be;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      grant_raw     = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || ls_req) begin
               grant_raw = 1'b1;
               state_nxt = ACCESS;
               if (pick_ls) begin
                  owner_nxt     = 1'b1;
                  mem_we_nxt    = ls_we;
                  mem_be_nxt    = ls_be;
                  mem_addr_nxt  = ls_addr;
                  mem_wdata_nxt = ls_wdata;
               end else begin
                  owner_nxt     = 1'b0;
                  mem_we_nxt    = 1'b0;
                  mem_be_nxt    = '1;
                  mem_addr_nxt  = if_addr;
                  mem_wdata_nxt = '0;
               end
            end
         end
         ACCESS: begin
            cnt_nxt   = LAT_M1;
            state_nxt = (MEM_LATENCY == 1) ? RESP : WAIT;
         end
         WAIT: begin
            cnt_nxt = cnt - 3'd1;
            if (cnt <= 3'd1)
               state_nxt = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and access registers advance only on enabled cycles; reset clears everything.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         owner_ls  <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (ce) begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         owner_ls  <= owner_nxt;
         mem_we    <= mem_we_nxt;
         mem_be    <= mem_be_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
      end
   end

   // Grants, strobe and response steering; a store ack returns zero data.
   always_comb begin
      if_gnt    = active & grant_raw & !pick_ls;
      ls_gnt    = active & grant_raw & pick_ls;
      mem_en    = active & (state == ACCESS);
      if_rvalid = active & (state == RESP) & !owner_ls;
      ls_rvalid = active & (state == RESP) & owner_ls;
      if_rdata  = if_rvalid ? mem_rdata : '0;
      ls_rdata  = (ls_rvalid && !mem_we) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: instance a runs MEM_LATENCY=1, instance b runs MEM_LATENCY=3.
// Both share the stimulus; each scenario checks the instance it targets.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ce = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        ls_req = 1'b0;
   logic        ls_we = 1'b0;
   logic [3:0]  ls_be = '0;
   logic [31:0] ls_addr = '0;
   logic [31:0] ls_wdata = '0;
   logic [31:0] mem_rdata = 32'hDEADBEEF;

   logic        a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_mem_en, a_mem_we;
   logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_be;
   logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_en, b_mem_we;
   logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata;
   logic [3:0]  b_mem_be;

   int vec = 0;
   int errs = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_a (
      .clk(clk), .reset(reset), .ce(ce),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(a_ls_gnt), .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut_b (
      .clk(clk), .reset(reset), .ce(ce),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) cyc();
      #1;
      vec++; if ({a_if_gnt, a_ls_gnt, a_if_rvalid, a_ls_rvalid, a_mem_en, a_mem_we} !== 6'b0) begin
         errs++; $display("FAIL reset_a_ctl: got %b want 000000", {a_if_gnt, a_ls_gnt, a_if_rvalid, a_ls_rvalid, a_mem_en, a_mem_we}); end
      vec++; if ({b_if_gnt, b_ls_gnt, b_if_rvalid, b_ls_rvalid, b_mem_en, b_mem_we} !== 6'b0) begin
         errs++; $display("FAIL reset_b_ctl: got %b want 000000", {b_if_gnt, b_ls_gnt, b_if_rvalid, b_ls_rvalid, b_mem_en, b_mem_we}); end
      vec++; if ({a_mem_be, a_mem_addr, a_mem_wdata, a_if_rdata, a_ls_rdata} !== '0) begin
         errs++; $display("FAIL reset_a_data: be=%h addr=%h wdata=%h want all 0", a_mem_be, a_mem_addr, a_mem_wdata); end
      vec++; if ({b_mem_be, b_mem_addr, b_mem_wdata, b_if_rdata, b_ls_rdata} !== '0) begin
         errs++; $display("FAIL reset_b_data: be=%h addr=%h wdata=%h want all 0", b_mem_be, b_mem_addr, b_mem_wdata); end
      cyc();
      reset = 1'b1;
   endtask

   task automatic test_if_read();
      cyc();
      if_req = 1'b1; if_addr = 32'h100;
      #1;
      vec++; if (a_if_gnt !== 1'b1 || a_ls_gnt !== 1'b0) begin
         errs++; $display("FAIL if_gnt: got if=%b ls=%b want if=1 ls=0", a_if_gnt, a_ls_gnt); end
      cyc();
      if_req = 1'b0; if_addr = 32'hFFF;
      #1;
      vec++; if (a_mem_en !== 1'b1 || a_mem_addr !== 32'h100) begin
         errs++; $display("FAIL if_access: got en=%b addr=%h want en=1 addr=00000100", a_mem_en, a_mem_addr); end
      vec++; if (a_mem_we !== 1'b0 || a_mem_be !== 4'hF || a_mem_wdata !== 32'h0 || a_if_rvalid !== 1'b0) begin
         errs++; $display("FAIL if_access_attr: got we=%b be=%h wd=%h rv=%b want 0 f 0 0", a_mem_we, a_mem_be, a_mem_wdata, a_if_rvalid); end
      cyc();
      #1;
      vec++; if (a_if_rvalid !== 1'b1 || a_if_rdata !== 32'hDEADBEEF || a_ls_rvalid !== 1'b0 || a_mem_en !== 1'b0) begin
         errs++; $display("FAIL if_resp: got rv=%b rd=%h lsrv=%b en=%b want 1 deadbeef 0 0", a_if_rvalid, a_if_rdata, a_ls_rvalid, a_mem_en); end
      vec++; if (a_mem_addr !== 32'h100) begin
         errs++; $display("FAIL if_resp_addr_hold: got %h want 00000100", a_mem_addr); end
      cyc();
      #1;
      vec++; if (a_if_rvalid !== 1'b0 || a_if_rdata !== 32'h0) begin
         errs++; $display("FAIL if_idle: got rv=%b rd=%h want 0 0", a_if_rvalid, a_if_rdata); end
      repeat (6) cyc();
   endtask

   task automatic test_store_load();
      cyc();
      ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h40; ls_wdata = 32'h12345678;
      #1;
      vec++; if (a_ls_gnt !== 1'b1 || a_if_gnt !== 1'b0) begin
         errs++; $display("FAIL st_gnt: got ls=%b if=%b want ls=1 if=0", a_ls_gnt, a_if_gnt); end
      cyc();
      ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h0; ls_wdata = 32'h0;
      #1;
      vec++; if ({a_mem_en, a_mem_we, a_mem_be} !== 6'b11_0011 || a_mem_addr !== 32'h40 || a_mem_wdata !== 32'h12345678) begin
         errs++; $display("FAIL st_access: got en=%b we=%b be=%b addr=%h wd=%h want 1 1 0011 40 12345678",
                          a_mem_en, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata); end
      cyc();
      #1;
      vec++; if ({a_mem_en, a_mem_we, a_mem_be} !== 6'b01_0011 || a_mem_wdata !== 32'h12345678) begin
         errs++; $display("FAIL st_hold: got en=%b we=%b be=%b wd=%h want 0 1 0011 12345678", a_mem_en, a_mem_we, a_mem_be, a_mem_wdata); end
      vec++; if (a_ls_rvalid !== 1'b1 || a_ls_rdata !== 32'h0 || a_if_rvalid !== 1'b0) begin
         errs++; $display("FAIL st_ack: got rv=%b rd=%h ifrv=%b want 1 0 0", a_ls_rvalid, a_ls_rdata, a_if_rvalid); end
      // Load issued in the earliest next-grant slot.
      cyc();
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44; mem_rdata = 32'hCAFEF00D;
      #1;
      vec++; if (a_ls_gnt !== 1'b1) begin
         errs++; $display("FAIL b2b_gnt: got %b want 1", a_ls_gnt); end
      cyc();
      ls_req = 1'b0;
      #1;
      vec++; if (a_mem_we !== 1'b0 || a_mem_addr !== 32'h44 || a_mem_be !== 4'hF) begin
         errs++; $display("FAIL ld_access: got we=%b addr=%h be=%h want 0 44 f", a_mem_we, a_mem_addr, a_mem_be); end
      cyc();
      #1;
      vec++; if (a_ls_rvalid !== 1'b1 || a_ls_rdata !== 32'hCAFEF00D) begin
         errs++; $display("FAIL ld_resp: got rv=%b rd=%h want 1 cafef00d", a_ls_rvalid, a_ls_rdata); end
      mem_rdata = 32'hDEADBEEF;
      repeat (6) cyc();
   endtask

   task automatic test_contention();
      logic [3:0] order;
      logic [3:0] exp_order;
      int         t [4];
      int         n;
      n = 0;
      order = '0;
`ifdef MEM_ARB_RR_EN
      exp_order = 4'b0101;   // bit i = 1 means grant i went to LS: LS,IF,LS,IF
`else
      exp_order = 4'b1111;
`endif
      do_reset();
      for (int c = 0; c < 20 && n < 4; c++) begin
         cyc();
         if (c == 0) begin
            if_req = 1'b1; if_addr = 32'h200;
            ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
         end
         #1;
         if (a_if_gnt && a_ls_gnt) begin
            vec++; errs++; $display("FAIL tie_double_gnt: got both grants at cycle %0d want one", c);
         end
         if (a_if_gnt || a_ls_gnt) begin
            order[n] = a_ls_gnt;
            t[n] = c;
            n++;
         end
      end
      if_req = 1'b0; ls_req = 1'b0;
      vec++; if (n !== 4) begin
         errs++; $display("FAIL tie_count: got %0d grants want 4", n); end
      else begin
         for (int i = 0; i < 4; i++) begin
            vec++; if (order[i] !== exp_order[i]) begin
               errs++; $display("FAIL tie_order%0d: got ls=%b want ls=%b", i, order[i], exp_order[i]); end
            vec++; if (t[i] !== 3 * i) begin
               errs++; $display("FAIL tie_spacing%0d: got cycle %0d want %0d", i, t[i], 3 * i); end
         end
      end
      repeat (8) cyc();
   endtask

   task automatic test_ce_wait();
      do_reset();
      cyc();
      if_req = 1'b1; if_addr = 32'h500;
      #1;
      vec++; if (b_if_gnt !== 1'b1) begin
         errs++; $display("FAIL ce_gnt: got %b want 1", b_if_gnt); end
      for (int k = 1; k <= 7; k++) begin
         cyc();
         if_req = 1'b0;
         ce = (k == 2 || k == 3) ? 1'b0 : 1'b1;
         if (k >= 2) begin ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h504; end
         #1;
         vec++; if (b_mem_en !== (k == 1) || b_if_rvalid !== (k == 6) || b_ls_gnt !== (k == 7) || b_if_gnt !== 1'b0) begin
            errs++; $display("FAIL ce_cycle%0d: got en=%b rv=%b lsgnt=%b ifgnt=%b want %b %b %b 0",
                             k, b_mem_en, b_if_rvalid, b_ls_gnt, b_if_gnt, k == 1, k == 6, k == 7); end
         if (k == 6) begin
            vec++; if (b_if_rdata !== 32'hDEADBEEF || b_ls_rvalid !== 1'b0) begin
               errs++; $display("FAIL ce_rdata: got %h lsrv=%b want deadbeef 0", b_if_rdata, b_ls_rvalid); end
         end
      end
      cyc();
      ls_req = 1'b0;
      repeat (8) cyc();
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      cyc();
      if_req = 1'b1; if_addr = 32'h600;
      #1;
      vec++; if (b_if_gnt !== 1'b1) begin
         errs++; $display("FAIL rw_gnt: got %b want 1", b_if_gnt); end
      cyc();
      #1;
      vec++; if (b_mem_en !== 1'b1 || b_if_gnt !== 1'b0) begin
         errs++; $display("FAIL rw_access: got en=%b gnt=%b want 1 0", b_mem_en, b_if_gnt); end
      cyc();
      reset = 1'b0;
      #1;
      vec++; if (b_if_gnt !== 1'b0) begin
         errs++; $display("FAIL rw_wait_gnt: got %b want 0", b_if_gnt); end
      cyc();
      #1;
      vec++; if ({b_if_gnt, b_ls_gnt, b_if_rvalid, b_ls_rvalid, b_mem_en, b_mem_we} !== 6'b0 ||
                 b_mem_addr !== 32'h0 || b_mem_be !== 4'h0) begin
         errs++; $display("FAIL rw_idle: got ctl=%b addr=%h be=%h want 0 0 0",
                          {b_if_gnt, b_ls_gnt, b_if_rvalid, b_ls_rvalid, b_mem_en, b_mem_we}, b_mem_addr, b_mem_be); end
      cyc();
      reset = 1'b1;
      #1;
      vec++; if (b_if_gnt !== 1'b1 || b_if_rvalid !== 1'b0) begin
         errs++; $display("FAIL rw_release: got gnt=%b rv=%b want 1 0", b_if_gnt, b_if_rvalid); end
      cyc();
      if_req = 1'b0;
      #1;
      vec++; if (b_mem_en !== 1'b1 || b_mem_addr !== 32'h600 || b_if_rvalid !== 1'b0) begin
         errs++; $display("FAIL rw_regrant: got en=%b addr=%h rv=%b want 1 600 0", b_mem_en, b_mem_addr, b_if_rvalid); end
      repeat (8) cyc();
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_store_load();
      test_contention();
      test_ce_wait();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
